// File: rtl/key_schedule.sv
// key_schedule: iterative AES-128/256 key expansion, one round key per clock.
// Define KEYSCHED_READPORT_EN to add 15x128 round-key storage and a read port.

module subByte #(
    parameter int WIDTH          = 32,
    parameter int ROM_WIDTH      = 20,
    parameter int SELECT_SUBBYTE = 0
) (
    input  logic [WIDTH-1:0] sub_in,
    output logic [WIDTH-1:0] sub_out
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // A ROM narrower than one byte cannot hold the table; use the logic form.
    localparam bit USE_ROM = (SELECT_SUBBYTE == 0) && (ROM_WIDTH >= 8);

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254, then the affine transform.
    function automatic logic [7:0] sbox_logic(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), b);
        r = gf_mul(r, r);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < WIDTH / 8; g++) begin : g_byte
        if (USE_ROM) begin : g_rom
            assign sub_out[g*8 +: 8] =
                SBOX[(255 - int'(sub_in[g*8 +: 8])) * 8 +: 8];
        end else begin : g_logic
            assign sub_out[g*8 +: 8] = sbox_logic(sub_in[g*8 +: 8]);
        end
    end
endmodule

module key_schedule #(
    parameter int KEY_WIDTH      = 256,
    parameter int DATA_WIDTH     = 128,
    parameter int ROM_WIDTH      = 20,
    parameter int SELECT_SUBBYTE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid_in,
    input  logic                  key_256,
    input  logic [KEY_WIDTH-1:0]  key_in,
    output logic                  key_ready_out,
    output logic                  rk_valid_out,
    output logic [DATA_WIDTH-1:0] rk_out,
    output logic [3:0]            rk_index_out,
    output logic                  done_out,
    input  logic [3:0]            rk_rd_addr,
    output logic [DATA_WIDTH-1:0] rk_rd_data
);
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t                state, state_d;
    logic                  mode_256, mode_256_d;
    logic [7:0]            rcon, rcon_d;
    logic [DATA_WIDTH-1:0] rk_prev, rk_prev_d;
    logic [DATA_WIDTH-1:0] rk_d;
    logic [3:0]            idx_d;
    logic                  valid_d, done_d, ready_d, wr_en;

    logic [3:0]            last_idx, nxt_idx;
    logic                  odd_step;
    logic [31:0]           last_word, sw_in, sw_out, temp;
    logic [31:0]           w0, w1, w2, w3;
    logic [DATA_WIDTH-1:0] base;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    assign last_idx  = mode_256 ? 4'd14 : 4'd10;
    assign nxt_idx   = rk_index_out + 4'd1;
    // AES-256 odd rounds take SubWord only: no rotate, no Rcon.
    assign odd_step  = mode_256 && nxt_idx[0];
    assign last_word = rk_out[31:0];
    assign sw_in     = odd_step ? last_word
                                : {last_word[23:0], last_word[31:24]};

    subByte #(
        .WIDTH          (32),
        .ROM_WIDTH      (ROM_WIDTH),
        .SELECT_SUBBYTE (SELECT_SUBBYTE)
    ) u_subword (
        .sub_in  (sw_in),
        .sub_out (sw_out)
    );

    assign temp = odd_step ? sw_out : (sw_out ^ {rcon, 24'h000000});
    assign base = mode_256 ? rk_prev : rk_out;
    assign w0   = base[127:96] ^ temp;
    assign w1   = base[95:64]  ^ w0;
    assign w2   = base[63:32]  ^ w1;
    assign w3   = base[31:0]   ^ w2;

    always_comb begin
        state_d    = state;
        mode_256_d = mode_256;
        rcon_d     = rcon;
        rk_prev_d  = rk_prev;
        rk_d       = rk_out;
        idx_d      = rk_index_out;
        valid_d    = rk_valid_out;
        ready_d    = key_ready_out;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_valid_in) begin
                    state_d    = EXPAND;
                    mode_256_d = key_256;
                    rcon_d     = 8'h01;
                    rk_d       = key_in[KEY_WIDTH-1 -: DATA_WIDTH];
                    rk_prev_d  = key_in[KEY_WIDTH-DATA_WIDTH-1 -: DATA_WIDTH];
                    idx_d      = 4'd0;
                    valid_d    = 1'b1;
                    ready_d    = 1'b0;
                    wr_en      = 1'b1;
                end
            end
            EXPAND: begin
                if (rk_index_out == last_idx) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    idx_d     = nxt_idx;
                    done_d    = (nxt_idx == last_idx);
                    wr_en     = 1'b1;
                    rk_prev_d = rk_out;
                    // AES-256 rk1 is the low key half parked in rk_prev.
                    if (mode_256 && rk_index_out == 4'd0) begin
                        rk_d = rk_prev;
                    end else begin
                        rk_d = {w0, w1, w2, w3};
                        if (!odd_step) rcon_d = xtime(rcon);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mode_256      <= 1'b0;
            rcon          <= 8'h01;
            rk_prev       <= '0;
            rk_out        <= '0;
            rk_index_out  <= 4'd0;
            rk_valid_out  <= 1'b0;
            done_out      <= 1'b0;
            key_ready_out <= 1'b1;
        end else begin
            state         <= state_d;
            mode_256      <= mode_256_d;
            rcon          <= rcon_d;
            rk_prev       <= rk_prev_d;
            rk_out        <= rk_d;
            rk_index_out  <= idx_d;
            rk_valid_out  <= valid_d;
            done_out      <= done_d;
            key_ready_out <= ready_d;
        end
    end

`ifdef KEYSCHED_READPORT_EN
    logic [DATA_WIDTH-1:0] storage [0:14];

    // Left unreset so round keys survive an aborted expansion.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) storage[idx_d] <= rk_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_rd_data <= '0;
        end else if (rk_rd_addr > 4'd14) begin
            rk_rd_data <= '0;
        end else begin
            rk_rd_data <= storage[rk_rd_addr];
        end
    end
`else
    logic unused_rd;
    assign unused_rd  = ^{rk_rd_addr, wr_en};
    assign rk_rd_data = '0;
`endif
endmodule

// File: tb/tb_key_schedule.sv
// tb_key_schedule: directed checks of key_schedule streaming, busy, reset
// and read-port behaviour against FIPS-197 vectors.

module tb_key_schedule;
    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid_in;
    logic         key_256;
    logic [255:0] key_in;
    logic         key_ready_out;
    logic         rk_valid_out;
    logic [127:0] rk_out;
    logic [3:0]   rk_index_out;
    logic         done_out;
    logic [3:0]   rk_rd_addr;
    logic [127:0] rk_rd_data;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] K128 =
        {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] EXP128 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] RK256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] RK256_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    key_schedule dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid_in  (key_valid_in),
        .key_256       (key_256),
        .key_in        (key_in),
        .key_ready_out (key_ready_out),
        .rk_valid_out  (rk_valid_out),
        .rk_out        (rk_out),
        .rk_index_out  (rk_index_out),
        .done_out      (done_out),
        .rk_rd_addr    (rk_rd_addr),
        .rk_rd_data    (rk_rd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (key_ready_out !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (key_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL wait_ready: ready=%b want 1", key_ready_out);
        end
    endtask

    task automatic start_key(input logic [255:0] k, input logic m);
        wait_ready();
        key_in       = k;
        key_256      = m;
        key_valid_in = 1'b1;
        step();
        key_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (key_ready_out !== 1'b1 || rk_valid_out !== 1'b0 ||
            done_out !== 1'b0 || rk_out !== 128'h0 ||
            rk_index_out !== 4'd0 || rk_rd_data !== 128'h0) begin
            bad++;
            $display("FAIL reset: rdy=%b vld=%b done=%b rk=%h idx=%0d rd=%h want 1 0 0 0 0 0",
                     key_ready_out, rk_valid_out, done_out, rk_out,
                     rk_index_out, rk_rd_data);
        end
    endtask

    task automatic test_aes128();
        start_key(K128, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            total++;
            if (rk_valid_out !== 1'b1 || rk_index_out !== 4'(i) ||
                rk_out !== EXP128[i] || done_out !== (i == 10)) begin
                bad++;
                $display("FAIL aes128_rk%0d: rk=%h idx=%0d done=%b want %h %0d %b",
                         i, rk_out, rk_index_out, done_out, EXP128[i], i, i == 10);
            end
            if (i < 10) step();
        end
        step();
        total++;
        if (key_ready_out !== 1'b1 || rk_valid_out !== 1'b0 || done_out !== 1'b0) begin
            bad++;
            $display("FAIL aes128_end: rdy=%b vld=%b done=%b want 1 0 0",
                     key_ready_out, rk_valid_out, done_out);
        end
    endtask

    task automatic test_read_port();
        rk_rd_addr = 4'd10;
        step();
        total++;
`ifdef KEYSCHED_READPORT_EN
        if (rk_rd_data !== EXP128[10]) begin
            bad++;
            $display("FAIL rd_addr10: got %h want %h", rk_rd_data, EXP128[10]);
        end
        rk_rd_addr = 4'd3;
        step();
        total++;
        if (rk_rd_data !== EXP128[3]) begin
            bad++;
            $display("FAIL rd_addr3: got %h want %h", rk_rd_data, EXP128[3]);
        end
`else
        if (rk_rd_data !== 128'h0) begin
            bad++;
            $display("FAIL rd_tied: got %h want 0", rk_rd_data);
        end
`endif
        rk_rd_addr = 4'd15;
        step();
        total++;
        if (rk_rd_data !== 128'h0) begin
            bad++;
            $display("FAIL rd_addr15: got %h want 0", rk_rd_data);
        end
        rk_rd_addr = 4'd0;
    endtask

    task automatic test_aes256();
        start_key(K256, 1'b1);
        for (int i = 0; i <= 14; i++) begin
            total++;
            if (rk_valid_out !== 1'b1 || rk_index_out !== 4'(i) ||
                done_out !== (i == 14)) begin
                bad++;
                $display("FAIL aes256_ctl%0d: vld=%b idx=%0d done=%b want 1 %0d %b",
                         i, rk_valid_out, rk_index_out, done_out, i, i == 14);
            end
            if (i == 0) begin
                total++;
                if (rk_out !== RK256_0) begin
                    bad++;
                    $display("FAIL aes256_rk0: got %h want %h", rk_out, RK256_0);
                end
            end
            if (i == 1) begin
                total++;
                if (rk_out !== RK256_1) begin
                    bad++;
                    $display("FAIL aes256_rk1: got %h want %h", rk_out, RK256_1);
                end
            end
            if (i == 2) begin
                total++;
                if (rk_out !== RK256_2) begin
                    bad++;
                    $display("FAIL aes256_rk2: got %h want %h", rk_out, RK256_2);
                end
            end
            if (i == 14) begin
                total++;
                if (rk_out !== RK256_14) begin
                    bad++;
                    $display("FAIL aes256_rk14: got %h want %h", rk_out, RK256_14);
                end
            end
            if (i < 14) step();
        end
        step();
    endtask

    task automatic test_back_to_back();
        start_key(K256, 1'b1);
        for (int i = 0; i < 14; i++) step();
        total++;
        if (rk_out !== RK256_14 || done_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_rk14: rk=%h done=%b want %h 1", rk_out, done_out, RK256_14);
        end
        key_in       = K128;
        key_256      = 1'b0;
        key_valid_in = 1'b1;
        step();
        total++;
        if (key_ready_out !== 1'b1 || rk_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: rdy=%b vld=%b want 1 0", key_ready_out, rk_valid_out);
        end
        step();
        key_valid_in = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            total++;
            if (rk_valid_out !== 1'b1 || rk_index_out !== 4'(i) ||
                rk_out !== EXP128[i] || done_out !== (i == 10)) begin
                bad++;
                $display("FAIL b2b_rk%0d: rk=%h idx=%0d done=%b want %h %0d %b",
                         i, rk_out, rk_index_out, done_out, EXP128[i], i, i == 10);
            end
            if (i < 10) step();
        end
        step();
    endtask

    task automatic test_busy();
        int n = 0;
        wait_ready();
        key_in       = K128;
        key_256      = 1'b0;
        key_valid_in = 1'b1;
        step();
        key_in  = K256;
        key_256 = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            total++;
            if (rk_out !== EXP128[i] || rk_index_out !== 4'(i) ||
                key_ready_out !== 1'b0) begin
                bad++;
                $display("FAIL busy_rk%0d: rk=%h idx=%0d rdy=%b want %h %0d 0",
                         i, rk_out, rk_index_out, key_ready_out, EXP128[i], i);
            end
            step();
        end
        total++;
        if (key_ready_out !== 1'b1 || rk_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL busy_t11: rdy=%b vld=%b want 1 0", key_ready_out, rk_valid_out);
        end
        step();
        key_valid_in = 1'b0;
        total++;
        if (rk_valid_out !== 1'b1 || rk_index_out !== 4'd0 ||
            rk_out !== RK256_0 || key_ready_out !== 1'b0) begin
            bad++;
            $display("FAIL busy_t12: vld=%b idx=%0d rk=%h rdy=%b want 1 0 %h 0",
                     rk_valid_out, rk_index_out, rk_out, key_ready_out, RK256_0);
        end
        while (done_out !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        total++;
        if (done_out !== 1'b1 || rk_out !== RK256_14) begin
            bad++;
            $display("FAIL busy_drain: done=%b rk=%h want 1 %h", done_out, rk_out, RK256_14);
        end
        step();
    endtask

    task automatic test_reset_mid();
        start_key(K128, 1'b0);
        for (int i = 0; i < 5; i++) step();
        total++;
        if (rk_index_out !== 4'd5 || rk_out !== EXP128[5]) begin
            bad++;
            $display("FAIL mid_rk5: idx=%0d rk=%h want 5 %h", rk_index_out, rk_out, EXP128[5]);
        end
        rst = 1'b1;
        #1;
        total++;
        if (rk_valid_out !== 1'b0 || key_ready_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_rst: vld=%b rdy=%b want 0 1", rk_valid_out, key_ready_out);
        end
        step();
        rst = 1'b0;
        total++;
        if (rk_valid_out !== 1'b0 || key_ready_out !== 1'b1 || done_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_after: vld=%b rdy=%b done=%b want 0 1 0",
                     rk_valid_out, key_ready_out, done_out);
        end
        start_key(K128, 1'b0);
        total++;
        if (rk_out !== EXP128[0] || rk_index_out !== 4'd0 || rk_valid_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_rk0: rk=%h idx=%0d vld=%b want %h 0 1",
                     rk_out, rk_index_out, rk_valid_out, EXP128[0]);
        end
        step();
        total++;
        if (rk_out !== EXP128[1] || rk_index_out !== 4'd1) begin
            bad++;
            $display("FAIL mid_rk1: rk=%h idx=%0d want %h 1", rk_out, rk_index_out, EXP128[1]);
        end
    endtask

    initial begin
        rst          = 1'b1;
        key_valid_in = 1'b0;
        key_256      = 1'b0;
        key_in       = '0;
        rk_rd_addr   = 4'd0;
        step();
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_aes128();
        test_read_port();
        test_aes256();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
